serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that sequences one shared 1-bit full-add slice over a WIDTH-bit operand pair, one bit per clock, LSB first.
- The slice is built from two half-adder cells (sum = x^y, carry = x&y) plus an OR for carry-out.
- Trades area for latency; sits beside the parallel adder path as the low-area alternative.
- Fixed start/busy/done handshake to the requesting logic.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- cin  input  1  carry-in; latched on accepted start
- busy  output  1  high while an operation is in progress (RUN and DONE states)
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result, held until the next accepted start
- cout  output  1  carry-out of MSB, held with sum

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset. Reset is sampled only on the clk rising edge.
- Reset: state=IDLE; busy=0; done=0; sum=0; cout=0; internal operand shift registers, carry register and bit counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b, cin into shift regA, shift regB and the carry reg; clears sum, cout and the counter; next state RUN.
  - start=0 stays in IDLE; outputs hold.
- RUN, each cycle:
  - Slice inputs are regA[0], regB[0] and carry.
  - Half-adder 1: p = regA[0]^regB[0], g1 = regA[0]&regB[0].
  - Half-adder 2: s = p^carry, g2 = p&carry.
  - New carry = g1|g2.
  - s shifts into sum from the MSB (sum <= {s, sum[WIDTH-1:1]}).
  - regA and regB shift right by 1; counter increments.
  - When counter == WIDTH-1 in RUN: next state DONE; cout <= new carry.
- DONE: done=1 for exactly this cycle, busy=1, sum/cout final; next state IDLE unconditionally.
- Latency: start sampled high at edge N → RUN cycles span edges N+1..N+WIDTH → done=1 in the cycle after edge N+WIDTH. With WIDTH=4, done is high 5 cycles after start.
- Throughput: one operation per WIDTH+2 cycles. The earliest re-accepted start is the first IDLE cycle after DONE.
- start while busy (RUN or DONE): ignored, no queueing; latched operands are unaffected.
- Operand inputs a, b, cin may change freely after the accept edge.
- sum/cout:
  - Hold their final value from DONE through IDLE until the next accepted start, which clears them to 0.
  - During RUN, sum is partial and not valid.
- reset asserted in any state, including mid-RUN: next edge forces the reset values. No done pulse is issued and the in-flight result is discarded.
- reset and start high on the same edge: reset wins.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1) (exact, no overflow loss).
- Counter never exceeds WIDTH-1 and never wraps; an illegal state encoding returns to IDLE.

Test Plan:
- Basic add, WIDTH=4: reset 2 cycles, then start with a=4'b0101, b=4'b0011, cin=0 → busy=1 from the next cycle; done pulse 5 cycles after start; sum=4'b1000, cout=0; busy=0 the cycle after done.
- Carry ripple: a=4'b1111, b=4'b0001, cin=0 → sum=4'b0000, cout=1. Then a=4'b1111, b=4'b1111, cin=1 → sum=4'b1111, cout=1.
- Start during busy: start accepted with a=3, b=4; hold start=1 and change a=9 throughout RUN → exactly one done, sum=4'd7, cout=0; second op accepted only in the first IDLE cycle.
- Mid-operation reset: start a=6, b=7; assert reset on the 2nd RUN cycle for 1 cycle → no done pulse; sum=0, cout=0, busy=0 after reset; subsequent a=1, b=1 → sum=2.
- Result hold and back-to-back: after done, sum/cout stable for 10 idle cycles. Next start clears them to 0 on the accept edge; new result correct.
- Random: 1000 random a, b, cin at WIDTH=4 and WIDTH=8, scoreboard {cout,sum} == a+b+cin, done spacing == WIDTH+1 after each accepted start.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-add slice, LSB first, one bit/clk.
// start/busy/done handshake; result held until the next accepted start.
module serial_add_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic p, g1, s, g2, c_new;

  // Full-add slice from two half adders plus the carry OR
  always_comb begin
    p     = rega_q[0] ^ regb_q[0];
    g1    = rega_q[0] & regb_q[0];
    s     = p ^ carry_q;
    g2    = p & carry_q;
    c_new = g1 | g2;
  end

  always_comb begin
    state_d = state_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rega_d  = a;
          regb_d  = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {s, sum_q[WIDTH-1:1]};
        rega_d  = rega_q >> 1;
        regb_d  = regb_q >> 1;
        carry_d = c_new;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = c_new;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rega_q  <= '0;
      regb_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=4 and WIDTH=8.
// Model: arithmetic a+b+cin plus a cycle-count timeline of each op.
module tb_serial_add_ctrl;

  typedef struct {
    logic [8:0] v;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_s [2];
  logic [7:0] a_s [2];
  logic [7:0] b_s [2];
  logic       cin_s [2];

  logic       busy4, done4, cout4;
  logic [3:0] sum4;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  int W [2] = '{4, 8};

  exp_t       sbq [2][$];
  bit         free [2];
  bit         indone [2];
  bit         jacc [2];
  int         rel [2];
  logic [8:0] cur [2];
  logic [8:0] held [2];
  int         cyc = 0;
  bit         armed = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_s[0]),
    .a(a_s[0][3:0]), .b(b_s[0][3:0]), .cin(cin_s[0]),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start_s[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  task automatic chk(string name, int k, logic [8:0] act, logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s w%0d cyc=%0d act=%h req=%h",
               name, W[k], cyc, act, req);
    end
  endtask

  // Reference timeline: accept when idle, done WIDTH edges later, idle next
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        free[k]   = 1;
        indone[k] = 0;
        jacc[k]   = 0;
        held[k]   = '0;
        sbq[k].delete();
      end else begin
        jacc[k] = 0;
        if (free[k]) begin
          if (start_s[k]) begin
            logic [8:0] m;
            exp_t e;
            m       = 9'((1 << W[k]) - 1);
            cur[k]  = (9'(a_s[k]) & m) + (9'(b_s[k]) & m) + 9'(cin_s[k]);
            e.v     = cur[k];
            e.acc   = cyc;
            sbq[k].push_back(e);
            free[k] = 0;
            jacc[k] = 1;
            held[k] = '0;
            rel[k]  = cyc + W[k] + 1;
          end
        end else if (cyc == rel[k] - 1) begin
          indone[k] = 1;
          held[k]   = cur[k];
        end else if (cyc == rel[k]) begin
          indone[k] = 0;
          free[k]   = 1;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        logic       bz, dn;
        logic [8:0] got;
        bz  = (k == 0) ? busy4 : busy8;
        dn  = (k == 0) ? done4 : done8;
        got = (k == 0) ? {4'b0, cout4, sum4} : {cout8, sum8};
        chk("busy", k, 9'(bz), 9'(!free[k]));
        chk("done", k, 9'(dn), 9'(indone[k]));
        if (dn === 1'b1) begin
          if (sbq[k].size() == 0) begin
            chk("spurious_done", k, 9'(1), 9'(0));
          end else begin
            exp_t e;
            e = sbq[k].pop_front();
            chk("result", k, got, e.v);
            chk("latency", k, 9'(cyc - e.acc), 9'(W[k] + 1));
          end
        end
        if (free[k] || indone[k])
          chk("hold", k, got, held[k]);
        if (jacc[k])
          chk("clear_on_start", k, got, 9'(0));
      end
    end
  end

  task automatic op(int k, logic [7:0] av, logic [7:0] bv, logic cv,
                    bit noise);
    int n;
    @(negedge clk);
    start_s[k] = 1'b1;
    a_s[k]     = av;
    b_s[k]     = bv;
    cin_s[k]   = cv;
    @(negedge clk);
    start_s[k] = 1'b0;
    n = 0;
    while (!free[k] && n < 40) begin
      if (noise) begin
        start_s[k] = 1'($urandom_range(0, 1));
        a_s[k]     = 8'($urandom);
        b_s[k]     = 8'($urandom);
        cin_s[k]   = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start_s[k] = 1'b0;
    if (n >= 40) chk("op_timeout", k, 9'(1), 9'(0));
  endtask

  task automatic rand_run(int k);
    for (int i = 0; i < 1000; i++) begin
      op(k, 8'($urandom), 8'($urandom), 1'($urandom), i % 3 == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      a_s[k]     = '0;
      b_s[k]     = '0;
      cin_s[k]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    armed = 1;
    @(negedge clk);

    op(0, 8'h5, 8'h3, 1'b0, 0);
    op(0, 8'hF, 8'h1, 1'b0, 0);
    op(0, 8'hF, 8'hF, 1'b1, 0);

    // start held high through busy; re-accepted only in first IDLE cycle
    @(negedge clk);
    start_s[0] = 1'b1;
    a_s[0]     = 8'd3;
    b_s[0]     = 8'd4;
    cin_s[0]   = 1'b0;
    @(negedge clk);
    a_s[0] = 8'd9;
    while (!free[0]) @(negedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    while (!free[0]) @(negedge clk);

    // reset in the second RUN cycle discards the op
    @(negedge clk);
    start_s[0] = 1'b1;
    a_s[0]     = 8'd6;
    b_s[0]     = 8'd7;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    op(0, 8'd1, 8'd1, 1'b0, 0);

    repeat (10) @(negedge clk);
    op(0, 8'd7, 8'd9, 1'b1, 0);
    op(1, 8'hFF, 8'h01, 1'b0, 0);

    fork
      rand_run(0);
      rand_run(1);
    join

    repeat (12) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("queue_empty", k, 9'(sbq[k].size()), 9'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
